sample_capture: RTL and testbench
=================================

// Module: sample_capture
// PURPOSE
// - Downstream of sequence_acquisition. Captures each ADC conversion result when the measurement completes.
// - Tags the result with the sequence sample index and queues it in a small FIFO for the MCU register/SPI readout.
// - Flags completion of a full AZ sequence, and records results dropped because the MCU read too slowly.
// PARAMETERS
// - DATA_W   24  width of ADC count word (adc_count_i)
// - DEPTH    4   FIFO entries; power of 2, >= 2
// - SEQCNT_W 8   width of completed-sequence counter
// PORTS
// - clk                  in   1                   system clock
// - reset_n              in   1                   reset (see below)
// - adc_measure_valid_i  in   1                   ADC done level; held high until the ADC is put back in reset
// - adc_count_i          in   DATA_W              ADC result, stable while adc_measure_valid_i is high
// - sample_idx_i         in   3                   sample_idx_last from sequence_acquisition; 3'b111 = none
// - p_seq_n_i            in   3                   sequence length, 1..4
// - rd_en_i              in   1                   1-cycle pop strobe from the MCU register read
// - clr_overrun_i        in   1                   1-cycle clear of overrun_o
// - rd_data_o            out  DATA_W+3            FIFO head {idx[2:0], count}; first-word-fall-through
// - fifo_level_o         out  $clog2(DEPTH)+1     number of entries held
// - empty_o              out  1                   level == 0
// - full_o               out  1                   level == DEPTH
// - overrun_o            out  1                   sticky; a tagged result was dropped
// - seq_done_o           out  1                   1-cycle pulse; last index of the sequence written
// - seq_count_o          out  SEQCNT_W            completed sequences; wraps
// BEHAVIOUR
// - Reset: reset_n, synchronous, active-low; clock clk.
//   - Reset state: FIFO empty; all outputs 0 except empty_o=1; state IDLE.
//   - valid_d resets to 1, so a valid level already high when reset releases is not captured.
// - Edge detect: valid_d <= adc_measure_valid_i every cycle. rise = valid & ~valid_d.
// - FSM IDLE: on rise (cycle N), data_r <= adc_count_i; go to TAG.
// - FSM TAG (cycle N+1): sample_idx_i is now updated by the upstream block. Go to IDLE unconditionally.
//   - idx==3'b111: discard; no write, no flag change.
//   - else if !full_o, or rd_en_i in the same cycle: push {idx,data_r}.
//   - else: drop the result; overrun_o <= 1.
// - Latency: rising edge -> entry visible on rd_data_o/level at N+2.
// - Valid must fall before the next rise, so TAG never overlaps a new capture. A rise seen in TAG is impossible by protocol; ignore it.
// - Pop: rd_en_i && !empty_o advances the head; level decrements. rd_en_i while empty is ignored (no underflow, no flag).
// - Push and pop in the same cycle: both happen; level unchanged. This applies when full too.
// - rd_data_o is undefined-but-stable while empty; the bench must not check it when empty_o=1.
// - seq_done_o: pulse at N+2 when the pushed idx == p_seq_n_i-1.
//   - A dropped result does not pulse.
//   - idx >= p_seq_n_i (seq_n reduced mid-run) does not pulse.
// - seq_count_o increments with each seq_done_o pulse; all-ones wraps to 0.
// - overrun_o: cleared by clr_overrun_i. If a drop and a clear occur in the same cycle, the set wins.
// - Pointers: log2(DEPTH)-bit, natural wrap. Level is kept as an explicit counter.
// - Reset mid-TAG: the pending result is discarded.
// STRUCTURE
// - defines.v: `SAMPLE_IDX_NONE 3'b111, `SAMPLE_IDX_W 3.
// - Sub-module sync_fifo (WIDTH, DEPTH): FWFT register array with push/pop/level/full/empty. Reusable by other readout paths.
// - This module holds the edge detect, 2-state FSM, overrun/seq logic and one sync_fifo instance.
// TESTING
// - Seq n=2, idx 0 then 1, counts 0x000111 / 0x000222 -> rd_data 0x0000111 then 0x1000222; one seq_done; seq_count=1.
// - Valid high at reset release, idx=7 afterwards -> no entry, empty_o stays 1, no seq_done.
// - 5 results without a pop, DEPTH=4 -> full_o=1, level=4, overrun_o=1; 5th dropped; first 4 read back in order.
// - Full FIFO + rd_en_i coincident with a TAG push -> level stays 4, overrun_o stays 0, order preserved.
// - rd_en_i on empty; clr_overrun_i coincident with a drop -> level 0 unchanged; overrun_o=1.
// - seq_n 4->2 while idx=3 pending -> entry written, no seq_done; the next idx=1 write pulses seq_done.

Source files
------------

// File: rtl/sample_capture_pkg.sv
// Shared types and constants for the ADC sample capture path.
package sample_capture_pkg;

    localparam int SAMPLE_IDX_W = 3;
    localparam logic [SAMPLE_IDX_W-1:0] SAMPLE_IDX_NONE = 3'b111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_TAG  = 1'b1
    } state_t;

    // True when idx is the final sample of a sequence of length seq_n (1..4).
    function automatic logic is_seq_last(input logic [SAMPLE_IDX_W-1:0] idx,
                                         input logic [SAMPLE_IDX_W-1:0] seq_n);
        return (seq_n != '0) && (idx == seq_n - SAMPLE_IDX_W'(1));
    endfunction

endpackage

// File: rtl/sample_capture_sync_fifo.sv
// First-word-fall-through register FIFO with an explicit level counter.
module sync_fifo #(
    parameter  int WIDTH = 27,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic [LVL_W-1:0] level,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             pop_ok;
    logic             push_ok;

    assign empty   = (level == '0);
    assign full    = (level == LVL_W'(DEPTH));
    assign rd_data = mem[rd_ptr];

    // A push into a full FIFO is allowed only when a pop frees the head slot in the same cycle.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/sample_capture.sv
// Captures each ADC result on the done edge, tags it with the sample index and queues it for readout.
module sample_capture
    import sample_capture_pkg::*;
#(
    parameter int DATA_W   = 24,
    parameter int DEPTH    = 4,
    parameter int SEQCNT_W = 8
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       adc_measure_valid_i,
    input  logic [DATA_W-1:0]          adc_count_i,
    input  logic [SAMPLE_IDX_W-1:0]    sample_idx_i,
    input  logic [SAMPLE_IDX_W-1:0]    p_seq_n_i,
    input  logic                       rd_en_i,
    input  logic                       clr_overrun_i,
    output logic [DATA_W+2:0]          rd_data_o,
    output logic [$clog2(DEPTH):0]     fifo_level_o,
    output logic                       empty_o,
    output logic                       full_o,
    output logic                       overrun_o,
    output logic                       seq_done_o,
    output logic [SEQCNT_W-1:0]        seq_count_o
);

    state_t            state;
    logic              valid_d;
    logic [DATA_W-1:0] data_r;
    logic              rise;
    logic              tag_valid;
    logic              push;
    logic              drop;

    assign rise      = adc_measure_valid_i && !valid_d;
    assign tag_valid = (state == ST_TAG) && (sample_idx_i != SAMPLE_IDX_NONE);
    assign push      = tag_valid && (!full_o || rd_en_i);
    assign drop      = tag_valid && !push;

    // The index is only valid one cycle after the capture edge, so the data waits a cycle in data_r.
    // valid_d resets high so a level already asserted at reset release is not mistaken for a new result.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            valid_d     <= 1'b1;
            data_r      <= '0;
            overrun_o   <= 1'b0;
            seq_done_o  <= 1'b0;
            seq_count_o <= '0;
        end else begin
            valid_d    <= adc_measure_valid_i;
            seq_done_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (rise) begin
                        data_r <= adc_count_i;
                        state  <= ST_TAG;
                    end
                end
                ST_TAG: begin
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
            if (drop) begin
                overrun_o <= 1'b1;
            end else if (clr_overrun_i) begin
                overrun_o <= 1'b0;
            end
            if (push && is_seq_last(sample_idx_i, p_seq_n_i)) begin
                seq_done_o  <= 1'b1;
                seq_count_o <= seq_count_o + SEQCNT_W'(1);
            end
        end
    end

    sync_fifo #(
        .WIDTH (DATA_W + 3),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .push_data ({sample_idx_i, data_r}),
        .pop       (rd_en_i),
        .rd_data   (rd_data_o),
        .level     (fifo_level_o),
        .full      (full_o),
        .empty     (empty_o)
    );

endmodule

// File: tb/tb_sample_capture.sv
// Bench for sample_capture: directed table, corner sequences and a randomized run against a queue model.
module tb_sample_capture;

    localparam int DATA_W   = 24;
    localparam int DEPTH    = 4;
    localparam int SEQCNT_W = 8;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              adc_measure_valid_i;
    logic [DATA_W-1:0] adc_count_i;
    logic [2:0]        sample_idx_i;
    logic [2:0]        p_seq_n_i;
    logic              rd_en_i;
    logic              clr_overrun_i;
    logic [DATA_W+2:0] rd_data_o;
    logic [2:0]        fifo_level_o;
    logic              empty_o;
    logic              full_o;
    logic              overrun_o;
    logic              seq_done_o;
    logic [7:0]        seq_count_o;

    int n_vectors     = 0;
    int n_miscompares = 0;

    // Reference model state: the FIFO contents as a queue plus the flags.
    logic [DATA_W+2:0] m_q [$];
    logic              m_over;
    logic              m_done;
    logic [7:0]        m_cnt;
    logic              m_prev;
    logic              m_pend;
    logic [DATA_W-1:0] m_pend_data;

    typedef struct {
        logic              valid;
        logic [DATA_W-1:0] count;
        logic [2:0]        idx;
        logic [2:0]        seq_n;
        logic              rd_en;
        logic              clr;
        logic [2:0]        exp_level;
        logic              exp_empty;
        logic              exp_done;
        logic [7:0]        exp_cnt;
        logic [DATA_W+2:0] exp_data;
    } vec_t;

    vec_t tbl [8];

    sample_capture #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .SEQCNT_W (SEQCNT_W)
    ) dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .adc_measure_valid_i (adc_measure_valid_i),
        .adc_count_i         (adc_count_i),
        .sample_idx_i        (sample_idx_i),
        .p_seq_n_i           (p_seq_n_i),
        .rd_en_i             (rd_en_i),
        .clr_overrun_i       (clr_overrun_i),
        .rd_data_o           (rd_data_o),
        .fifo_level_o        (fifo_level_o),
        .empty_o             (empty_o),
        .full_o              (full_o),
        .overrun_o           (overrun_o),
        .seq_done_o          (seq_done_o),
        .seq_count_o         (seq_count_o)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vectors++;
        if (act !== exp) begin
            n_miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Applies the effect of one clock edge to the model, using the inputs currently driven.
    task automatic modelEdge();
        bit popped;
        bit pushed;
        bit dropped;
        popped  = 0;
        pushed  = 0;
        dropped = 0;
        if (!reset_n) begin
            m_q.delete();
            m_over = 0;
            m_done = 0;
            m_cnt  = 0;
            m_prev = 1;
            m_pend = 0;
            m_pend_data = '0;
            return;
        end
        m_done = 0;
        popped = rd_en_i && (m_q.size() > 0);
        if (m_pend && sample_idx_i != 3'b111) begin
            if (m_q.size() < DEPTH || rd_en_i) pushed = 1;
            else dropped = 1;
        end
        if (popped) void'(m_q.pop_front());
        if (pushed) m_q.push_back({sample_idx_i, m_pend_data});
        if (dropped) m_over = 1;
        else if (clr_overrun_i) m_over = 0;
        if (pushed && int'(sample_idx_i) == int'(p_seq_n_i) - 1) begin
            m_done = 1;
            m_cnt  = m_cnt + 8'd1;
        end
        if (m_pend) begin
            m_pend = 0;
        end else if (adc_measure_valid_i && !m_prev) begin
            m_pend      = 1;
            m_pend_data = adc_count_i;
        end
        m_prev = adc_measure_valid_i;
    endtask

    task automatic checkOutput();
        checkVal("level", 32'(fifo_level_o), 32'(m_q.size()));
        checkVal("empty", 32'(empty_o), 32'(m_q.size() == 0));
        checkVal("full", 32'(full_o), 32'(m_q.size() == DEPTH));
        checkVal("overrun", 32'(overrun_o), 32'(m_over));
        checkVal("seq_done", 32'(seq_done_o), 32'(m_done));
        checkVal("seq_count", 32'(seq_count_o), 32'(m_cnt));
        if (m_q.size() > 0) begin
            checkVal("rd_data", 32'(rd_data_o), 32'(m_q[0]));
        end
    endtask

    task automatic stepCycle();
        modelEdge();
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    task automatic applyStimulus(input vec_t v);
        adc_measure_valid_i = v.valid;
        adc_count_i         = v.count;
        sample_idx_i        = v.idx;
        p_seq_n_i           = v.seq_n;
        rd_en_i             = v.rd_en;
        clr_overrun_i       = v.clr;
    endtask

    task automatic resetDut(input logic valid_level);
        reset_n             = 1'b0;
        adc_measure_valid_i = valid_level;
        adc_count_i         = '0;
        sample_idx_i        = 3'b111;
        rd_en_i             = 1'b0;
        clr_overrun_i       = 1'b0;
        stepCycle();
        stepCycle();
        reset_n = 1'b1;
        stepCycle();
    endtask

    // One ADC result: rise with idx still 'none', then the real idx (and seq_n) in the tag cycle.
    task automatic captureResult(input logic [DATA_W-1:0] count, input logic [2:0] idx,
                                 input logic [2:0] seqn_tag, input logic rd, input logic clr,
                                 output logic done_seen);
        adc_measure_valid_i = 1'b1;
        adc_count_i         = count;
        sample_idx_i        = 3'b111;
        stepCycle();
        sample_idx_i  = idx;
        p_seq_n_i     = seqn_tag;
        rd_en_i       = rd;
        clr_overrun_i = clr;
        stepCycle();
        done_seen           = seq_done_o;
        adc_measure_valid_i = 1'b0;
        sample_idx_i        = 3'b111;
        rd_en_i             = 1'b0;
        clr_overrun_i       = 1'b0;
        stepCycle();
    endtask

    task automatic popExpect(input logic [DATA_W+2:0] exp);
        checkVal("pop_head", 32'(rd_data_o), 32'(exp));
        rd_en_i = 1'b1;
        stepCycle();
        rd_en_i = 1'b0;
    endtask

    initial begin
        logic done;
        p_seq_n_i = 3'd2;

        tbl[0] = '{1'b1, 24'h000111, 3'd7, 3'd2, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 8'd0, 27'h0000000};
        tbl[1] = '{1'b1, 24'h000111, 3'd0, 3'd2, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 8'd0, 27'h0000111};
        tbl[2] = '{1'b0, 24'h000111, 3'd7, 3'd2, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 8'd0, 27'h0000111};
        tbl[3] = '{1'b1, 24'h000222, 3'd7, 3'd2, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 8'd0, 27'h0000111};
        tbl[4] = '{1'b1, 24'h000222, 3'd1, 3'd2, 1'b0, 1'b0, 3'd2, 1'b0, 1'b1, 8'd1, 27'h0000111};
        tbl[5] = '{1'b0, 24'h000222, 3'd7, 3'd2, 1'b1, 1'b0, 3'd1, 1'b0, 1'b0, 8'd1, 27'h1000222};
        tbl[6] = '{1'b0, 24'h000222, 3'd7, 3'd2, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 8'd1, 27'h0000000};
        tbl[7] = '{1'b0, 24'h000222, 3'd7, 3'd2, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 8'd1, 27'h0000000};

        resetDut(1'b0);
        checkVal("reset_level", 32'(fifo_level_o), 32'd0);
        checkVal("reset_empty", 32'(empty_o), 32'd1);
        checkVal("reset_full", 32'(full_o), 32'd0);
        checkVal("reset_overrun", 32'(overrun_o), 32'd0);
        checkVal("reset_seq_count", 32'(seq_count_o), 32'd0);

        $display("[TB] directed table: two-sample sequence");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(tbl[i]);
            stepCycle();
            checkVal($sformatf("tbl%0d_level", i), 32'(fifo_level_o), 32'(tbl[i].exp_level));
            checkVal($sformatf("tbl%0d_empty", i), 32'(empty_o), 32'(tbl[i].exp_empty));
            checkVal($sformatf("tbl%0d_done", i), 32'(seq_done_o), 32'(tbl[i].exp_done));
            checkVal($sformatf("tbl%0d_cnt", i), 32'(seq_count_o), 32'(tbl[i].exp_cnt));
            if (!tbl[i].exp_empty) begin
                checkVal($sformatf("tbl%0d_data", i), 32'(rd_data_o), 32'(tbl[i].exp_data));
            end
        end
        rd_en_i = 1'b0;

        $display("[TB] valid already high at reset release");
        resetDut(1'b1);
        for (int i = 0; i < 3; i++) stepCycle();
        checkVal("hold_empty", 32'(empty_o), 32'd1);
        checkVal("hold_done", 32'(seq_done_o), 32'd0);
        adc_measure_valid_i = 1'b0;
        stepCycle();

        $display("[TB] five results without a pop");
        p_seq_n_i = 3'd4;
        for (int i = 0; i < 5; i++) begin
            captureResult(24'(32'hA01 + i), 3'(i % 4), 3'd4, 1'b0, 1'b0, done);
            checkVal($sformatf("fill%0d_done", i), 32'(done), 32'(i == 3));
        end
        checkVal("fill_full", 32'(full_o), 32'd1);
        checkVal("fill_level", 32'(fifo_level_o), 32'd4);
        checkVal("fill_overrun", 32'(overrun_o), 32'd1);
        popExpect(27'h0000A01);
        popExpect(27'h1000A02);
        popExpect(27'h2000A03);
        popExpect(27'h3000A04);
        checkVal("drain_empty", 32'(empty_o), 32'd1);
        clr_overrun_i = 1'b1;
        stepCycle();
        clr_overrun_i = 1'b0;
        checkVal("clr_overrun", 32'(overrun_o), 32'd0);

        $display("[TB] push with coincident pop while full");
        for (int i = 0; i < 4; i++) captureResult(24'(32'hB01 + i), 3'(i), 3'd4, 1'b0, 1'b0, done);
        captureResult(24'hB05, 3'd0, 3'd4, 1'b1, 1'b0, done);
        checkVal("fullpop_level", 32'(fifo_level_o), 32'd4);
        checkVal("fullpop_overrun", 32'(overrun_o), 32'd0);
        popExpect(27'h1000B02);
        popExpect(27'h2000B03);
        popExpect(27'h3000B04);
        popExpect(27'h0000B05);

        $display("[TB] read while empty, clear coincident with drop");
        rd_en_i = 1'b1;
        stepCycle();
        rd_en_i = 1'b0;
        checkVal("underflow_level", 32'(fifo_level_o), 32'd0);
        checkVal("underflow_overrun", 32'(overrun_o), 32'd0);
        for (int i = 0; i < 4; i++) captureResult(24'(32'hC01 + i), 3'(i), 3'd4, 1'b0, 1'b0, done);
        captureResult(24'hC05, 3'd0, 3'd4, 1'b0, 1'b1, done);
        checkVal("setwins_overrun", 32'(overrun_o), 32'd1);
        checkVal("setwins_level", 32'(fifo_level_o), 32'd4);
        for (int i = 0; i < 4; i++) popExpect(27'((i << 24) | (32'hC01 + i)));
        clr_overrun_i = 1'b1;
        stepCycle();
        clr_overrun_i = 1'b0;

        $display("[TB] sequence length reduced mid-run");
        captureResult(24'hD03, 3'd3, 3'd2, 1'b0, 1'b0, done);
        checkVal("seqn_idx3_done", 32'(done), 32'd0);
        checkVal("seqn_idx3_level", 32'(fifo_level_o), 32'd1);
        captureResult(24'hD01, 3'd1, 3'd2, 1'b0, 1'b0, done);
        checkVal("seqn_idx1_done", 32'(done), 32'd1);

        $display("[TB] randomized run");
        for (int i = 0; i < 1500; i++) begin
            reset_n = ($urandom_range(0, 199) != 0);
            if ($urandom_range(0, 2) == 0) adc_measure_valid_i = ~adc_measure_valid_i;
            adc_count_i   = 24'($urandom);
            sample_idx_i  = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 49) == 0) p_seq_n_i = 3'($urandom_range(1, 4));
            rd_en_i       = ($urandom_range(0, 3) == 0);
            clr_overrun_i = ($urandom_range(0, 15) == 0);
            stepCycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
